// File: rtl/pll_scan_ctrl.sv
// Loads one PLL scan-chain image bit-serially from a latency-N ROM into a cache,
// then shifts it into the PLL on reconfig, strobes configupdate and waits for lock.
module pll_scan_ctrl #(
    parameter int SCAN_LEN      = 144,
    parameter int ROM_LATENCY   = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 4096
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       trigger_read,
    input  logic       reconfig,
    input  logic       rom_q,
    input  logic       pll_locked,
    output logic [7:0] rom_address,
    output logic       rom_read_ena,
    output logic       busy,
    output logic       scanclk,
    output logic       scanclkena,
    output logic       scandata,
    output logic       configupdate,
    output logic       lock_error,
    output logic [2:0] state_dbg
);

    // Handshake: trigger_read and reconfig are single-cycle request pulses with no
    // ready; busy is the only back-pressure and requests that arrive while busy are
    // either latched (reconfig during a load) or dropped, never queued further.

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        SHIFT,
        UPDATE,
        SETTLE,
        LOCKWAIT
    } state_t;

    localparam int M1 = (2 * SCAN_LEN > LOCK_TIMEOUT) ? 2 * SCAN_LEN : LOCK_TIMEOUT;
    localparam int M2 = (M1 > SETTLE_CYCLES) ? M1 : SETTLE_CYCLES;
    localparam int CNT_MAX = (M2 > ROM_LATENCY) ? M2 : ROM_LATENCY;
    localparam int CW = $clog2(CNT_MAX) + 1;

    localparam logic [7:0]    LAST_ADDR   = 8'(SCAN_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(ROM_LATENCY - 1);
    localparam logic [CW-1:0] SHIFT_LAST  = CW'(2 * SCAN_LEN - 1);
    localparam logic [CW-1:0] UPDATE_LAST = CW'(1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);

    state_t state, state_next;

    logic [CW-1:0]          cnt;
    logic [SCAN_LEN-1:0]    cache;
    logic                   cache_valid;
    logic                   pending;
    logic [ROM_LATENCY-1:0] cap_vld;
    logic [7:0]             cap_addr [ROM_LATENCY];
    logic                   locked_meta;
    logic                   locked_sync;
    logic [7:0]             bit_idx;
    logic                   shifting_now;
    logic                   shifting_next;

    assign state_dbg = state;

    // Each cache bit spans two clocks: one scanclk low phase and one high phase.
    assign bit_idx       = 8'(cnt >> 1);
    assign shifting_now  = (state == SHIFT) || (state == UPDATE);
    assign shifting_next = (state_next == SHIFT) || (state_next == UPDATE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        rom_read_ena = 1'b0;
        busy         = (state != IDLE);
        scanclkena   = 1'b0;
        scandata     = 1'b0;
        configupdate = 1'b0;
        unique case (state)
            IDLE: begin
                if (trigger_read) begin
                    state_next = LOAD;
                end else if ((reconfig || pending) && cache_valid) begin
                    state_next = SHIFT;
                end
            end
            LOAD: begin
                rom_read_ena = 1'b1;
                if (rom_address == LAST_ADDR) state_next = DRAIN;
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) state_next = IDLE;
            end
            SHIFT: begin
                scanclkena = 1'b1;
                scandata   = cache[bit_idx];
                if (cnt == SHIFT_LAST) state_next = UPDATE;
            end
            UPDATE: begin
                scanclkena   = 1'b1;
                configupdate = 1'b1;
                if (cnt == UPDATE_LAST) state_next = SETTLE;
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) state_next = LOCKWAIT;
            end
            LOCKWAIT: begin
                if (locked_sync || (cnt == LOCK_LAST)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            rom_address <= '0;
            cache       <= '0;
            cache_valid <= 1'b0;
            pending     <= 1'b0;
            cap_vld     <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) cap_addr[i] <= '0;
            scanclk     <= 1'b0;
            lock_error  <= 1'b0;
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_sync <= locked_meta;

            // One counter serves every timed state; it restarts on each transition.
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            if ((state == IDLE) && (state_next == LOAD)) begin
                rom_address <= '0;
            end else if ((state == LOAD) && (rom_address != LAST_ADDR)) begin
                rom_address <= rom_address + 1'b1;
            end

            // Address/enable delay line aligned with the ROM read latency.
            cap_vld[0]  <= rom_read_ena;
            cap_addr[0] <= rom_address;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                cap_vld[i]  <= cap_vld[i-1];
                cap_addr[i] <= cap_addr[i-1];
            end
            if (cap_vld[ROM_LATENCY-1]) cache[cap_addr[ROM_LATENCY-1]] <= rom_q;

            if ((state == IDLE) && (state_next == LOAD)) begin
                cache_valid <= 1'b0;
            end else if ((state == DRAIN) && (state_next == IDLE)) begin
                cache_valid <= 1'b1;
            end

            if ((state == IDLE) && trigger_read && reconfig) begin
                pending <= 1'b1;
            end else if (((state == LOAD) || (state == DRAIN)) && reconfig) begin
                pending <= 1'b1;
            end else if ((state == IDLE) && (state_next == SHIFT)) begin
                pending <= 1'b0;
            end

            // Registered so the PLL never sees a decode glitch on its scan clock.
            if (shifting_now && shifting_next) begin
                scanclk <= ~scanclk;
            end else begin
                scanclk <= 1'b0;
            end

            if (state == LOCKWAIT) begin
                if (locked_sync) begin
                    lock_error <= 1'b0;
                end else if (cnt == LOCK_LAST) begin
                    lock_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_scan_ctrl.sv
// Directed bench for pll_scan_ctrl: table-driven cycle checkpoints plus
// hand-written load / shift / pending / reset sequences against a latency-2 ROM model.
module tb_pll_scan_ctrl;

    logic       clock;
    logic       reset_n;
    logic       trigger_read;
    logic       reconfig;
    logic       rom_q;
    logic       pll_locked;
    logic [7:0] rom_address;
    logic       rom_read_ena;
    logic       busy;
    logic       scanclk;
    logic       scanclkena;
    logic       scandata;
    logic       configupdate;
    logic       lock_error;
    logic [2:0] state_dbg;

    pll_scan_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .trigger_read (trigger_read),
        .reconfig     (reconfig),
        .rom_q        (rom_q),
        .pll_locked   (pll_locked),
        .rom_address  (rom_address),
        .rom_read_ena (rom_read_ena),
        .busy         (busy),
        .scanclk      (scanclk),
        .scanclkena   (scanclkena),
        .scandata     (scandata),
        .configupdate (configupdate),
        .lock_error   (lock_error),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ROM model: two-clock read latency
    int         rom_mode;
    logic [7:0] rom_a1;
    logic [7:0] rom_a2;

    function automatic logic rom_bit(input logic [7:0] a, input int mode);
        if (mode == 0) return a[0];
        return ((a % 3) == 0) ^ a[4];
    endfunction

    always @(posedge clock) begin
        rom_a1 <= rom_address;
        rom_a2 <= rom_a1;
    end
    assign rom_q = rom_bit(rom_a2, rom_mode);

    // scoreboard
    int         n_checks;
    int         n_errors;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [14:0] out_vec();
        return {busy, rom_read_ena, rom_address, scanclk, scanclkena, scandata,
                configupdate, lock_error};
    endfunction

    // driver tasks
    task automatic do_reset();
        reset_n      = 1'b0;
        trigger_read = 1'b0;
        reconfig     = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic pulse(input logic trig, input logic recfg);
        trigger_read = trig;
        reconfig     = recfg;
        @(negedge clock);
        trigger_read = 1'b0;
        reconfig     = 1'b0;
    endtask

    task automatic fill_exp(input int mode);
        exp_q.delete();
        for (int i = 0; i < 144; i++) exp_q.push_back(rom_bit(8'(i), mode));
    endtask

    // per-operation monitor: runs from the current negedge until busy drops
    int w_busy, w_ena, w_addr_err, w_cfg, w_clkena, w_bits, w_bit_err, w_quiet_err;

    task automatic watch(input string name, input int bound, input int poke_at);
        int   n;
        logic b;
        n = 0;
        w_busy = 0; w_ena = 0; w_addr_err = 0; w_cfg = 0;
        w_clkena = 0; w_bits = 0; w_bit_err = 0; w_quiet_err = 0;
        while (busy) begin
            if (n >= bound) begin
                check({name, "_timeout"}, 1, 0);
                break;
            end
            if (rom_read_ena) begin
                if (rom_address != 8'(w_ena)) w_addr_err++;
                w_ena++;
            end
            if (scanclkena) w_clkena++;
            if (configupdate) w_cfg++;
            if (scanclkena && scanclk && !configupdate) begin
                if (exp_q.size() == 0) begin
                    w_bit_err++;
                end else begin
                    b = exp_q.pop_front();
                    if (scandata !== b) w_bit_err++;
                end
                w_bits++;
            end
            if (!scanclkena && (scanclk || scandata || configupdate)) w_quiet_err++;
            trigger_read = (n == poke_at);
            n++;
            w_busy = n;
            @(negedge clock);
        end
        trigger_read = 1'b0;
    endtask

    // checkpoint table
    typedef struct {
        logic       trig;
        logic       recfg;
        logic       locked;
        int         wait_n;
        logic       e_busy;
        logic       e_ena;
        logic [7:0] e_addr;
        logic       e_clkena;
        logic       e_sclk;
        logic       e_cfg;
        logic       e_lerr;
    } vec_t;

    function automatic vec_t mk(input logic tg, input logic rc, input logic lk, input int w,
                                input logic b, input logic en, input logic [7:0] ad,
                                input logic ce, input logic sc, input logic cu, input logic le);
        vec_t v;
        v.trig = tg; v.recfg = rc; v.locked = lk; v.wait_n = w;
        v.e_busy = b; v.e_ena = en; v.e_addr = ad; v.e_clkena = ce;
        v.e_sclk = sc; v.e_cfg = cu; v.e_lerr = le;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rom_mode     = 1;
        pll_locked   = 1'b1;
        reset_n      = 1'b0;
        trigger_read = 1'b0;
        reconfig     = 1'b0;

        //             tg rc lk wait  busy ena addr clke sclk cfg lerr
        vecs[0]  = mk(0, 1, 0, 1,    0, 0, 8'd0,   0, 0, 0, 0); // reconfig with empty cache dropped
        vecs[1]  = mk(1, 0, 0, 1,    1, 1, 8'd0,   0, 0, 0, 0); // first LOAD cycle
        vecs[2]  = mk(0, 0, 0, 143,  1, 1, 8'd143, 0, 0, 0, 0); // last LOAD cycle
        vecs[3]  = mk(0, 0, 0, 2,    1, 0, 8'd143, 0, 0, 0, 0); // DRAIN cycle 1
        vecs[4]  = mk(0, 1, 0, 1,    0, 0, 8'd143, 0, 0, 0, 0); // reconfig latched, IDLE
        vecs[5]  = mk(0, 0, 0, 1,    1, 0, 8'd143, 1, 0, 0, 0); // pending -> SHIFT0
        vecs[6]  = mk(1, 0, 0, 1,    1, 0, 8'd143, 1, 1, 0, 0); // trigger in SHIFT ignored
        vecs[7]  = mk(0, 0, 0, 286,  1, 0, 8'd143, 1, 1, 0, 0); // last SHIFT cycle
        vecs[8]  = mk(0, 0, 0, 1,    1, 0, 8'd143, 1, 0, 1, 0); // UPDATE0
        vecs[9]  = mk(0, 0, 0, 1,    1, 0, 8'd143, 1, 1, 1, 0); // UPDATE1
        vecs[10] = mk(0, 0, 0, 1,    1, 0, 8'd143, 0, 0, 0, 0); // SETTLE0
        vecs[11] = mk(0, 0, 0, 4111, 1, 0, 8'd143, 0, 0, 0, 0); // last LOCKWAIT cycle
        vecs[12] = mk(0, 0, 0, 1,    0, 0, 8'd143, 0, 0, 0, 1); // timeout -> lock_error
        vecs[13] = mk(0, 1, 1, 1,    1, 0, 8'd143, 1, 0, 0, 1); // re-shift from cache
        vecs[14] = mk(0, 0, 1, 306,  1, 0, 8'd143, 0, 0, 0, 1); // LOCKWAIT0
        vecs[15] = mk(0, 0, 1, 1,    0, 0, 8'd143, 0, 0, 0, 0); // lock clears lock_error

        do_reset();
        check("reset_outputs", 32'(out_vec()), 0);

        // load with patterned ROM
        pulse(1'b1, 1'b0);
        watch("load1", 400, -1);
        check("load1_busy", w_busy, 146);
        check("load1_ena", w_ena, 144);
        check("load1_addr_seq", w_addr_err, 0);
        check("load1_addr_hold", 32'(rom_address), 143);
        check("load1_quiet", w_quiet_err, 0);

        // shift that image out; a trigger poked mid-shift must not start a read
        fill_exp(1);
        pulse(1'b0, 1'b1);
        check("shift1_first_sclk", 32'(scanclk), 0);
        check("shift1_first_data", 32'(scandata), 32'(rom_bit(8'd0, 1)));
        watch("shift1", 5000, 60);
        check("shift1_busy", w_busy, 307);
        check("shift1_bits", w_bits, 144);
        check("shift1_bit_err", w_bit_err, 0);
        check("shift1_cfg", w_cfg, 2);
        check("shift1_clkena", w_clkena, 290);
        check("shift1_no_read", w_ena, 0);
        check("shift1_quiet", w_quiet_err, 0);
        check("shift1_lerr", 32'(lock_error), 0);

        // trigger and reconfig together: load first, shift follows from pending
        rom_mode = 0;
        pulse(1'b1, 1'b1);
        watch("load2", 400, -1);
        check("load2_busy", w_busy, 146);
        @(negedge clock);
        check("pending_busy", 32'(busy), 1);
        check("pending_clkena", 32'(scanclkena), 1);
        fill_exp(0);
        watch("shift2", 5000, -1);
        check("shift2_bits", w_bits, 144);
        check("shift2_bit_err", w_bit_err, 0);
        check("shift2_busy", w_busy, 307);

        // checkpoint table from a fresh reset
        do_reset();
        for (int i = 0; i < 16; i++) begin
            trigger_read = vecs[i].trig;
            reconfig     = vecs[i].recfg;
            pll_locked   = vecs[i].locked;
            @(negedge clock);
            trigger_read = 1'b0;
            reconfig     = 1'b0;
            repeat (vecs[i].wait_n - 1) @(negedge clock);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_ena", i), 32'(rom_read_ena), 32'(vecs[i].e_ena));
            check($sformatf("vec%0d_addr", i), 32'(rom_address), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_clkena", i), 32'(scanclkena), 32'(vecs[i].e_clkena));
            check($sformatf("vec%0d_scanclk", i), 32'(scanclk), 32'(vecs[i].e_sclk));
            check($sformatf("vec%0d_cfgupd", i), 32'(configupdate), 32'(vecs[i].e_cfg));
            check($sformatf("vec%0d_lockerr", i), 32'(lock_error), 32'(vecs[i].e_lerr));
        end

        // reset during SHIFT at bit 70, then reconfig without reload is dropped
        pulse(1'b0, 1'b1);
        repeat (140) @(negedge clock);
        check("bit70_busy", 32'(busy), 1);
        check("bit70_sclk", 32'(scanclk), 0);
        check("bit70_data", 32'(scandata), 32'(rom_bit(8'd70, 0)));
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", 32'(out_vec()), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        pulse(1'b0, 1'b1);
        check("post_reset_reconfig_busy", 32'(busy), 0);
        check("post_reset_reconfig_clkena", 32'(scanclkena), 0);
        repeat (5) @(negedge clock);
        check("post_reset_idle", 32'(out_vec()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
